// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Holds parameter defaults, the address-width function and the hard-wired zero register.
package rf_pkg;

  localparam int DEPTH_DEFAULT = 32;
  localparam int BITS_DEFAULT  = 64;
  localparam int ZERO_REG      = 0;

  // Guard keeps the address at least one bit wide for tiny files.
  function automatic int aw_of(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write tracking for the register file.
// Holds busy bits, accepts reservations, counts busy registers and flags stray writebacks.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = aw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  output logic             issue_ready,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      busy_count,
  output logic             wb_err
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic             wb_hit;
  logic             set_hit;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      count_nxt;
  logic             err_nxt;

  always_comb begin
    wb_hit      = wr_en && (wr_addr != ZERO_ADDR);
    issue_ready = (issue_addr == ZERO_ADDR) || !busy[issue_addr] ||
                  (wr_en && (wr_addr == issue_addr));
    set_hit     = issue_en && issue_ready && (issue_addr != ZERO_ADDR);

    // Reservation applied after the clear so a same-address set wins.
    busy_nxt = busy;
    if (wb_hit)
      busy_nxt[wr_addr] = 1'b0;
    if (set_hit)
      busy_nxt[issue_addr] = 1'b1;

    cnt_inc   = set_hit && !busy[issue_addr];
    cnt_dec   = wb_hit && busy[wr_addr] && !(set_hit && (issue_addr == wr_addr));
    count_nxt = busy_count + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);

    err_nxt = wb_err || (wb_hit && !busy[wr_addr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
      wb_err     <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
      wb_err     <= err_nxt;
    end
  end

endmodule

// File: rtl/scoreboard_reg_file.sv
// Register file with write bypass and a pending-writeback scoreboard.
// Data array and read muxes live here; reservation tracking is in rf_scoreboard.
module scoreboard_reg_file
  import rf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int BITS  = BITS_DEFAULT,
  parameter int NREAD = 2,
  localparam int AW   = aw_of(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREAD-1:0][AW-1:0]   rd_addr,
  output logic [NREAD-1:0][BITS-1:0] rd_data,
  output logic [NREAD-1:0]           rd_busy,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [BITS-1:0]            wr_data,
  input  logic                       issue_en,
  input  logic [AW-1:0]              issue_addr,
  output logic                       issue_ready,
  output logic [AW:0]                busy_count,
  output logic                       wb_err
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [BITS-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wb_hit;

  assign wb_hit = wr_en && (wr_addr != ZERO_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (rd_addr[i] != ZERO_ADDR) begin
        if (wb_hit && (wr_addr == rd_addr[i])) begin
          rd_data[i] = wr_data;
          rd_busy[i] = 1'b0;
        end else begin
          rd_data[i] = regs[rd_addr[i]];
          rd_busy[i] = busy[rd_addr[i]];
        end
      end
    end
  end

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .busy        (busy),
    .busy_count  (busy_count),
    .wb_err      (wb_err)
  );

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Self-checking bench for scoreboard_reg_file: directed scenarios plus random traffic.
// Expected outputs are queued per cycle by the driver and compared by a separate monitor.
module tb_scoreboard_reg_file;

  localparam int DEPTH = 32;
  localparam int BITS  = 64;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NREAD-1:0][AW-1:0]   rd_addr = '0;
  logic [NREAD-1:0][BITS-1:0] rd_data;
  logic [NREAD-1:0]           rd_busy;
  logic                       wr_en = 1'b0;
  logic [AW-1:0]              wr_addr = '0;
  logic [BITS-1:0]            wr_data = '0;
  logic                       issue_en = 1'b0;
  logic [AW-1:0]              issue_addr = '0;
  logic                       issue_ready;
  logic [AW:0]                busy_count;
  logic                       wb_err;

  scoreboard_reg_file #(.DEPTH(DEPTH), .BITS(BITS), .NREAD(NREAD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .busy_count  (busy_count),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREAD-1:0][BITS-1:0] data;
    logic [NREAD-1:0]           busy;
    logic                       ready;
    logic [AW:0]                cnt;
    logic                       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain arrays updated by the architectural rules.
  logic [BITS-1:0] m_regs [DEPTH];
  bit              m_busy [DEPTH];
  bit              m_err;

  function automatic int popcount_busy();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic void check(string name, logic [BITS-1:0] act, logic [BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops the expectation for the current cycle mid-period.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int i = 0; i < NREAD; i++) begin
        check($sformatf("rd_data[%0d]", i), rd_data[i], e.data[i]);
        check($sformatf("rd_busy[%0d]", i), BITS'(rd_busy[i]), BITS'(e.busy[i]));
      end
      check("issue_ready", BITS'(issue_ready), BITS'(e.ready));
      check("busy_count", BITS'(busy_count), BITS'(e.cnt));
      check("wb_err", BITS'(wb_err), BITS'(e.err));
    end
  end

  // Drive one cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit we, input int wa, input logic [BITS-1:0] wd,
                       input bit ie, input int ia, input int ra0, input int ra1);
    exp_t e;
    bit   ready;
    int   ra [NREAD];
    ra[0] = ra0;
    ra[1] = ra1;
    wr_en      = we;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = AW'(ia);
    for (int i = 0; i < NREAD; i++) rd_addr[i] = AW'(ra[i]);

    ready = (ia == 0) || !m_busy[ia] || (we && wa == ia);
    for (int i = 0; i < NREAD; i++) begin
      if (ra[i] == 0) begin
        e.data[i] = '0;
        e.busy[i] = 1'b0;
      end else if (we && wa == ra[i]) begin
        e.data[i] = wd;
        e.busy[i] = 1'b0;
      end else begin
        e.data[i] = m_regs[ra[i]];
        e.busy[i] = m_busy[ra[i]];
      end
    end
    e.ready = ready;
    e.cnt   = (AW+1)'(popcount_busy());
    e.err   = m_err;
    exp_q.push_back(e);

    @(posedge clk);
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      if (!m_busy[wa]) m_err = 1'b1;
      m_busy[wa] = 1'b0;
    end
    if (ie && ready && ia != 0) m_busy[ia] = 1'b1;
    #1;
  endtask

  task automatic idle(input int ra0, input int ra1);
    cycle(0, 0, '0, 0, 0, ra0, ra1);
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input int ra);
    wr_en      = 1'b0;
    issue_en   = 1'b0;
    rd_addr[0] = AW'(ra);
    rd_addr[1] = AW'(ra);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst busy_count", BITS'(busy_count), '0);
    check("rst wb_err", BITS'(wb_err), '0);
    check("rst rd_data", rd_data[0], '0);
    check("rst rd_busy", BITS'(rd_busy[0]), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int busy_list[$];
  int wa, ia;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset(5);

    // Write then read r5 from storage on both ports.
    cycle(1, 5, 64'hDEAD, 0, 0, 0, 0);
    idle(5, 5);
    // Register 0 ignores writes and never reserves.
    cycle(1, 0, 64'h1234, 0, 0, 0, 0);
    idle(0, 0);
    cycle(0, 0, '0, 1, 0, 0, 0);
    idle(0, 0);
    do_reset(5);

    // WAW stall, then writeback-while-issue on r7.
    cycle(0, 0, '0, 1, 7, 7, 0);
    cycle(0, 0, '0, 1, 7, 7, 0);
    cycle(1, 7, 64'h55, 1, 7, 7, 7);
    idle(7, 0);
    cycle(1, 7, 64'h77, 0, 0, 7, 0);
    idle(7, 0);

    // Fill every register, then drain them all.
    for (int r = 1; r < DEPTH; r++) cycle(0, 0, '0, 1, r, r, r - 1);
    idle(31, 1);
    for (int r = 1; r < DEPTH; r++) cycle(1, r, BITS'(r * 3 + 1), 0, 0, r, (r % 31) + 1);
    idle(1, 31);

    // Stray writeback: error sticks, data still lands.
    cycle(1, 9, 64'hABCD_0009, 0, 0, 9, 0);
    idle(9, 9);
    cycle(0, 0, '0, 1, 4, 9, 4);
    idle(4, 9);

    // Reservation discarded by a mid-cycle reset.
    cycle(0, 0, '0, 1, 3, 3, 0);
    do_reset(3);
    idle(3, 9);

    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < 400; n++) begin
        busy_list.delete();
        for (int i = 1; i < DEPTH; i++) if (m_busy[i]) busy_list.push_back(i);
        if (busy_list.size() > 0 && $urandom_range(0, 9) < 8)
          wa = busy_list[$urandom_range(0, busy_list.size() - 1)];
        else
          wa = $urandom_range(0, DEPTH - 1);
        ia = ($urandom_range(0, 7) == 0) ? wa : $urandom_range(0, DEPTH - 1);
        cycle($urandom_range(0, 1), wa, {$urandom, $urandom}, $urandom_range(0, 1), ia,
              ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1),
              $urandom_range(0, DEPTH - 1));
      end
      do_reset($urandom_range(0, DEPTH - 1));
    end

    idle(0, 0);
    @(negedge clk);
    check("queue drained", BITS'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
